// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point add/subtract with valid/ready flow control.
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_pipe #(
   parameter int unsigned EXP_SIZE    = 8,
   parameter int unsigned MANTIS_SIZE = 23
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            op,
   input  logic [EXP_SIZE+MANTIS_SIZE:0]   a,
   input  logic [EXP_SIZE+MANTIS_SIZE:0]   b,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [EXP_SIZE+MANTIS_SIZE:0]   result,
   output logic                            overflow,
   output logic                            underflow,
   output logic                            inexact
);

   localparam int unsigned W  = 1 + EXP_SIZE + MANTIS_SIZE;
   localparam int unsigned MW = MANTIS_SIZE + 4;
   localparam int unsigned EW = EXP_SIZE + 2;
   localparam logic [EXP_SIZE-1:0] FAR_SHIFT = EXP_SIZE'(MANTIS_SIZE + 3);
   localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_SIZE{1'b1}}};

   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // ---------------- stage 1: compare / align ----------------
   logic                   a_sign, b_sign_eff, a_zero, b_zero, a_ge_b;
   logic [EXP_SIZE-1:0]    a_exp, b_exp, x_exp, y_exp, exp_diff;
   logic [MANTIS_SIZE-1:0] a_frac, b_frac, x_frac, y_frac;
   logic                   x_sign, y_sign;
   logic [MW-1:0]          y_ext, y_shift, lost_mask, y_align;
   logic [W-1:0]           byp_res;

   assign a_sign     = a[W-1];
   assign a_exp      = a[W-2:MANTIS_SIZE];
   assign a_frac     = a[MANTIS_SIZE-1:0];
   assign b_sign_eff = b[W-1] ^ op;
   assign b_exp      = b[W-2:MANTIS_SIZE];
   assign b_frac     = b[MANTIS_SIZE-1:0];
   assign a_zero     = (a_exp == '0);
   assign b_zero     = (b_exp == '0);
   assign a_ge_b     = {a_exp, a_frac} >= {b_exp, b_frac};

   assign x_sign   = a_ge_b ? a_sign : b_sign_eff;
   assign y_sign   = a_ge_b ? b_sign_eff : a_sign;
   assign x_exp    = a_ge_b ? a_exp : b_exp;
   assign y_exp    = a_ge_b ? b_exp : a_exp;
   assign x_frac   = a_ge_b ? a_frac : b_frac;
   assign y_frac   = a_ge_b ? b_frac : a_frac;
   assign exp_diff = x_exp - y_exp;

   always_comb begin
      y_ext     = {1'b1, y_frac, 3'b000};
      y_shift   = '0;
      lost_mask = '0;
      y_align   = '0;
      if (exp_diff >= FAR_SHIFT) begin
         // everything lands below R; only the sticky survives
         y_align = {{(MW-1){1'b0}}, 1'b1};
      end else begin
         y_shift   = y_ext >> exp_diff;
         lost_mask = ~({MW{1'b1}} << exp_diff);
         y_align   = {y_shift[MW-1:1], y_shift[0] | (|(y_ext & lost_mask))};
      end
   end

   always_comb begin
      byp_res = a;
      if (a_zero && b_zero) begin
         byp_res = {a_sign & b_sign_eff, {(W-1){1'b0}}};
      end else if (a_zero) begin
         byp_res = {b_sign_eff, b[W-2:0]};
      end
   end

   logic                s1_valid, s1_sign, s1_sub, s1_byp;
   logic [EXP_SIZE-1:0] s1_exp;
   logic [MW-1:0]       s1_xm, s1_ym;
   logic [W-1:0]        s1_byp_res;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_sub     <= 1'b0;
         s1_byp     <= 1'b0;
         s1_exp     <= '0;
         s1_xm      <= '0;
         s1_ym      <= '0;
         s1_byp_res <= '0;
      end else if (advance) begin
         s1_valid   <= in_valid;
         s1_sign    <= x_sign;
         s1_sub     <= x_sign ^ y_sign;
         s1_byp     <= a_zero | b_zero;
         s1_exp     <= x_exp;
         s1_xm      <= {1'b1, x_frac, 3'b000};
         s1_ym      <= y_align;
         s1_byp_res <= byp_res;
      end
   end

   // ---------------- stage 2: add / subtract ----------------
   logic [MW:0] sum;
   // the swap guarantees X >= Y, so the difference never goes negative
   assign sum = s1_sub ? ({1'b0, s1_xm} - {1'b0, s1_ym}) : ({1'b0, s1_xm} + {1'b0, s1_ym});

   logic                s2_valid, s2_sign, s2_byp;
   logic [EXP_SIZE-1:0] s2_exp;
   logic [MW:0]         s2_sum;
   logic [W-1:0]        s2_byp_res;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         s2_sign    <= 1'b0;
         s2_byp     <= 1'b0;
         s2_exp     <= '0;
         s2_sum     <= '0;
         s2_byp_res <= '0;
      end else if (advance) begin
         s2_valid   <= s1_valid;
         s2_sign    <= s1_sign;
         s2_byp     <= s1_byp;
         s2_exp     <= s1_exp;
         s2_sum     <= sum;
         s2_byp_res <= s1_byp_res;
      end
   end

   // ---------------- stage 3: normalise / round ----------------
   logic [EW-1:0]          exp_w, lzc, norm_exp, round_exp;
   logic [MW-1:0]          mant;
   logic [MANTIS_SIZE:0]   sig;
   logic [MANTIS_SIZE-1:0] frac;
   logic                   grs;
   logic [W-1:0]           res_d;
   logic                   ov_d, uf_d, ix_d;
`ifdef FP_ROUND_NEAREST_EN
   logic                   inc;
   logic [MANTIS_SIZE+1:0] sig_r;
`endif

   always_comb begin
      exp_w     = {2'b00, s2_exp};
      lzc       = '0;
      mant      = '0;
      norm_exp  = '0;
      round_exp = '0;
      frac      = '0;
      res_d     = '0;
      ov_d      = 1'b0;
      uf_d      = 1'b0;
      ix_d      = 1'b0;
`ifdef FP_ROUND_NEAREST_EN
      inc       = 1'b0;
      sig_r     = '0;
`endif
      if (s2_sum[MW]) begin
         mant     = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
         norm_exp = exp_w + 1'b1;
      end else begin
         for (int i = 0; i < MW; i++) begin
            if (s2_sum[i]) lzc = EW'(MW - 1 - i);
         end
         mant     = s2_sum[MW-1:0] << lzc;
         norm_exp = exp_w - lzc;
      end
      grs = |mant[2:0];
      sig = mant[MW-1:3];
`ifdef FP_ROUND_NEAREST_EN
      inc   = mant[2] & (mant[1] | mant[0] | mant[3]);
      sig_r = {1'b0, sig} + {{(MANTIS_SIZE+1){1'b0}}, inc};
      if (sig_r[MANTIS_SIZE+1]) begin
         frac      = sig_r[MANTIS_SIZE:1];
         round_exp = norm_exp + 1'b1;
      end else begin
         frac      = sig_r[MANTIS_SIZE-1:0];
         round_exp = norm_exp;
      end
`else
      frac      = sig[MANTIS_SIZE-1:0];
      round_exp = norm_exp;
`endif
      if (s2_byp) begin
         res_d = s2_byp_res;
      end else if (s2_sum == '0) begin
         res_d = '0;
      end else if (norm_exp[EW-1] || (norm_exp == '0)) begin
         res_d = {s2_sign, {(W-1){1'b0}}};
         uf_d  = 1'b1;
         ix_d  = 1'b1;
      end else if (round_exp >= EXP_MAX) begin
         res_d = {s2_sign, {EXP_SIZE{1'b1}}, {MANTIS_SIZE{1'b0}}};
         ov_d  = 1'b1;
         ix_d  = grs;
      end else begin
         res_d = {s2_sign, round_exp[EXP_SIZE-1:0], frac};
         ix_d  = grs;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         inexact   <= 1'b0;
      end else if (advance) begin
         out_valid <= s2_valid;
         result    <= res_d;
         overflow  <= ov_d;
         underflow <= uf_d;
         inexact   <= ix_d;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (single precision) using a result scoreboard.
module tb_fp_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        overflow, underflow, inexact;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] res;
      logic        ov;
      logic        uf;
      logic        ix;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic        ov;
      logic        uf;
      logic        ix;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   fp_addsub_pipe #(
      .EXP_SIZE    (8),
      .MANTIS_SIZE (23)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow),
      .inexact   (inexact)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                               input logic [31:0] r, input logic ov, input logic uf,
                               input logic ix);
      vec_t v;
      v.a = av; v.b = bv; v.op = opv; v.res = r; v.ov = ov; v.uf = uf; v.ix = ix;
      return v;
   endfunction

   task automatic load_vectors();
      vecs.push_back(mk(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 0, 0, 0));
      vecs.push_back(mk(32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 0, 0, 0));
      vecs.push_back(mk(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 0, 0, 0));
      vecs.push_back(mk(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 0, 0, 0));
      vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0, 0, 0));
      vecs.push_back(mk(32'h00000000, 32'hC0000000, 1'b0, 32'hC0000000, 0, 0, 0));
      vecs.push_back(mk(32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 0, 0, 0));
      vecs.push_back(mk(32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 0, 0, 0));
      vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 0, 0, 0));
      vecs.push_back(mk(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 0, 0, 0));
      vecs.push_back(mk(32'h40800000, 32'h3F000000, 1'b1, 32'h40600000, 0, 0, 0));
      vecs.push_back(mk(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 0, 0, 0));
      vecs.push_back(mk(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 0, 1, 1));
      vecs.push_back(mk(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 0, 0, 1));
      vecs.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1, 0, 0));
      vecs.push_back(mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 0, 0, 1));
`ifdef FP_ROUND_NEAREST_EN
      vecs.push_back(mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 0, 0, 1));
`else
      vecs.push_back(mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 0, 0, 1));
`endif
      vecs.push_back(mk(32'hC0000000, 32'h40400000, 1'b0, 32'h3F800000, 0, 0, 0));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if ({result, overflow, underflow, inexact} !== 35'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h/%b%b%b exp=0", result, overflow, underflow, inexact);
      end
   endtask

   task automatic test_latency();
      @(negedge clk);
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000; op = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL lat_accept got=%b exp=1", in_ready);
      end
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         checks++;
         if (out_valid !== (c == 3)) begin
            failures++; $display("FAIL lat_valid_c%0d got=%b exp=%b", c, out_valid, c == 3);
         end
         if (c == 3) begin
            checks++;
            if ({result, overflow, underflow, inexact} !== {32'h40400000, 3'b000}) begin
               failures++;
               $display("FAIL lat_result got=%h/%b%b%b exp=40400000/000", result, overflow,
                        underflow, inexact);
            end
         end
      end
   endtask

   task automatic test_vectors();
      int   idx = 0;
      int   got = 0;
      int   cyc = 0;
      exp_t e;
      sb_q.delete();
      while ((idx < vecs.size() || sb_q.size() > 0) && cyc < 200) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (idx < vecs.size()) begin
            in_valid = 1'b1; a = vecs[idx].a; b = vecs[idx].b; op = vecs[idx].op;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) begin
            sb_q.push_back({vecs[idx].res, vecs[idx].ov, vecs[idx].uf, vecs[idx].ix});
            idx++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++; $display("FAIL vec_extra got=%h exp=none", result);
            end else begin
               e = sb_q.pop_front();
               if ({result, overflow, underflow, inexact} !== e) begin
                  failures++;
                  $display("FAIL vec[%0d] got=%h/%b%b%b exp=%h/%b%b%b", got, result, overflow,
                           underflow, inexact, e.res, e.ov, e.uf, e.ix);
               end
               got++;
            end
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got != vecs.size()) begin
         failures++; $display("FAIL vec_count got=%0d exp=%0d", got, vecs.size());
      end
   endtask

   task automatic test_back_to_back();
      int   idx = 0;
      int   got = 0;
      int   cyc = 0;
      exp_t e;
      logic stall;
      sb_q.delete();
      while ((idx < 8 || sb_q.size() > 0) && cyc < 100) begin
         @(negedge clk);
         stall = (cyc >= 5 && cyc <= 8);
         out_ready = ~stall;
         if (idx < 8) begin
            in_valid = 1'b1; a = vecs[idx].a; b = vecs[idx].b; op = vecs[idx].op;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stall) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
               failures++;
               $display("FAIL stall_ready c%0d got=v%b/r%b exp=v1/r0", cyc, out_valid, in_ready);
            end
            checks++;
            if (sb_q.size() == 0) begin
               failures++; $display("FAIL stall_hold c%0d got=%h exp=none", cyc, result);
            end else if (result !== sb_q[0].res) begin
               failures++;
               $display("FAIL stall_hold c%0d got=%h exp=%h", cyc, result, sb_q[0].res);
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back({vecs[idx].res, vecs[idx].ov, vecs[idx].uf, vecs[idx].ix});
            idx++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++; $display("FAIL b2b_extra got=%h exp=none", result);
            end else begin
               e = sb_q.pop_front();
               if ({result, overflow, underflow, inexact} !== e) begin
                  failures++;
                  $display("FAIL b2b[%0d] got=%h/%b%b%b exp=%h/%b%b%b", got, result, overflow,
                           underflow, inexact, e.res, e.ov, e.uf, e.ix);
               end
               got++;
            end
         end
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 8 || idx != 8) begin
         failures++; $display("FAIL b2b_count got=%0d/%0d exp=8/8", got, idx);
      end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0) begin
         failures++; $display("FAIL rst_mid_clear got=v%b/%h exp=v0/0", out_valid, result);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; a = 32'h3FC00000; b = 32'h3E800000; op = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL rst_mid_accept got=%b exp=1", in_ready);
      end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         checks++;
         if (out_valid !== (c == 3)) begin
            failures++; $display("FAIL rst_mid_valid_c%0d got=%b exp=%b", c, out_valid, c == 3);
         end
      end
      checks++;
      if ({result, overflow, underflow, inexact} !== {32'h3FE00000, 3'b000}) begin
         failures++;
         $display("FAIL rst_mid_result got=%h/%b%b%b exp=3FE00000/000", result, overflow,
                  underflow, inexact);
      end
      @(negedge clk);
   endtask

   initial begin
      load_vectors();
      test_reset();
      test_latency();
      test_vectors();
      test_back_to_back();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
